// File: rtl/mul_partial_resolve.sv
// mul_partial_resolve
// Final stage of the partial-product reduction path. Three 156-bit partial
// sums are compressed 3:2 into a carry-save pair on accept. The pair is then
// resolved by a narrow CHUNK-bit adder over NCH cycles, so no full-width
// carry chain is needed. The product is presented as two RADIX-bit digits
// behind a valid/ready handshake.
module mul_partial_resolve #(
    parameter int RADIX = 78,
    parameter int CHUNK = 26
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*RADIX-1:0] res_0,
    input  logic [2*RADIX-1:0] res_1,
    input  logic [2*RADIX-1:0] res_2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [RADIX-1:0]   digit_lo,
    output logic [RADIX-1:0]   digit_hi,
    output logic               ovf
);

    // Datapath width, number of resolve steps and chunk-index width.
    // 2*RADIX must be a whole multiple of CHUNK.
    localparam int W   = 2 * RADIX;
    localparam int NCH = W / CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Control state
    logic [1:0]    r_state;
    logic [KW-1:0] r_k;
    logic          r_in_ready;
    logic          r_out_valid;

    // Carry-save pair, running result and carries
    logic [W-1:0]  r_s;
    logic [W-1:0]  r_c;
    logic [W-1:0]  r_res;
    logic          r_cy;
    logic          r_ovf;

    // Output holding registers; only updated when a result completes
    logic [RADIX-1:0] r_dlo;
    logic [RADIX-1:0] r_dhi;
    logic             r_ovf_o;

    // Combinational helpers
    logic             w_accept;
    logic             w_last;
    logic             w_release;
    logic [W-1:0]     w_maj;
    logic [CHUNK-1:0] w_s_chunk;
    logic [CHUNK-1:0] w_c_chunk;
    logic [CHUNK:0]   w_sum;
    logic [W-1:0]     w_res_next;

    // Handshake qualifiers. Accept needs the registered in_ready so that
    // nothing is taken in the first cycle after reset release.
    assign w_accept  = (r_state == ST_IDLE) && in_valid && r_in_ready;
    assign w_last    = (r_state == ST_ADD) && (r_k == K_LAST);
    assign w_release = (r_state == ST_DONE) && out_ready;

    // 3:2 compressor carry term (before the left shift)
    assign w_maj = (res_0 & res_1) | (res_0 & res_2) | (res_1 & res_2);

    // Select the sum and carry chunks addressed by the current index k
    always_comb begin
        w_s_chunk = '0;
        w_c_chunk = '0;
        for (int j = 0; j < NCH; j++) begin
            if (int'(r_k) == j) begin
                w_s_chunk = r_s[j*CHUNK +: CHUNK];
                w_c_chunk = r_c[j*CHUNK +: CHUNK];
            end
        end
    end

    // One chunk of the carry-propagate add; the top bit is the chunk carry-out
    assign w_sum = {1'b0, w_s_chunk} + {1'b0, w_c_chunk} + {{CHUNK{1'b0}}, r_cy};

    // Running result with the current chunk merged in
    always_comb begin
        w_res_next = r_res;
        for (int j = 0; j < NCH; j++) begin
            if (int'(r_k) == j) begin
                w_res_next[j*CHUNK +: CHUNK] = w_sum[CHUNK-1:0];
            end
        end
    end

    // Controller: state, chunk index and both handshake flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_k         <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state    <= ST_ADD;
                        r_k        <= '0;
                        r_in_ready <= 1'b0;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                ST_ADD: begin
                    if (w_last) begin
                        r_state     <= ST_DONE;
                        r_k         <= '0;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (w_release) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_k         <= '0;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Capture the carry-save pair on accept; the bit shifted out of the
    // carry vector is already a lost carry and seeds the overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s <= '0;
            r_c <= '0;
        end else if (w_accept) begin
            r_s <= res_0 ^ res_1 ^ res_2;
            r_c <= {w_maj[W-2:0], 1'b0};
        end
    end

    // Chunked carry resolve: one CHUNK-bit add per cycle while in ADD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res <= '0;
            r_cy  <= 1'b0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_cy  <= 1'b0;
            r_ovf <= w_maj[W-1];
        end else if (r_state == ST_ADD) begin
            r_res <= w_res_next;
            r_cy  <= w_sum[CHUNK];
            if (w_last) begin
                r_ovf <= r_ovf | w_sum[CHUNK];
            end
        end
    end

    // Output registers load only when the last chunk completes, so they
    // hold the previous product through IDLE and ADD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dlo   <= '0;
            r_dhi   <= '0;
            r_ovf_o <= 1'b0;
        end else if (w_last) begin
            r_dlo   <= w_res_next[RADIX-1:0];
            r_dhi   <= w_res_next[W-1:RADIX];
            r_ovf_o <= r_ovf | w_sum[CHUNK];
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign digit_lo  = r_dlo;
    assign digit_hi  = r_dhi;
    assign ovf       = r_ovf_o;

endmodule

// File: tb/tb_mul_partial_resolve.sv
// Self-checking bench for mul_partial_resolve: directed carry cases,
// backpressure, reset abort and a randomized soak against a plain-arithmetic
// reference sum.
module tb_mul_partial_resolve;

    localparam int RADIX = 78;
    localparam int W     = 2 * RADIX;
    localparam int LAT   = 6;
    localparam int BOUND = 40;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     res_0;
    logic [W-1:0]     res_1;
    logic [W-1:0]     res_2;
    logic             out_valid;
    logic             out_ready;
    logic [RADIX-1:0] digit_lo;
    logic [RADIX-1:0] digit_hi;
    logic             ovf;

    int n_vec;
    int n_err;

    mul_partial_resolve #(.RADIX(RADIX), .CHUNK(26)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .res_0     (res_0),
        .res_1     (res_1),
        .res_2     (res_2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .digit_lo  (digit_lo),
        .digit_hi  (digit_hi),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact sum in a wider integer
    function automatic logic [W+1:0] ref_sum(input logic [W-1:0] a, b, c);
        return {2'b00, a} + {2'b00, b} + {2'b00, c};
    endfunction

    // Random 156-bit value with a bias toward carry-heavy patterns
    function automatic logic [W-1:0] rnd156();
        logic [159:0] v;
        v = {$urandom, $urandom, $urandom, $urandom, $urandom};
        case ($urandom_range(0, 4))
            0: return {W{1'b1}};
            1: return W'(v[15:0]);
            2: return {1'b1, v[W-2:0]};
            3: return {W{1'b1}} ^ W'(v[7:0]);
            default: return v[W-1:0];
        endcase
    endfunction

    // Advance one clock; inputs are driven and outputs sampled 1 time unit
    // after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a triple and hold it until the accept edge has passed
    task automatic send(input logic [W-1:0] a, b, c, output bit ok);
        int n;
        res_0 = a; res_1 = b; res_2 = c;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < BOUND) begin
            tick();
            n++;
        end
        ok = in_ready;
        tick();
        in_valid = 1'b0;
    endtask

    // Count cycles from the accept edge until out_valid shows
    task automatic wait_out(output int lat, output bit ok);
        lat = 0;
        while (!out_valid && lat < BOUND) begin
            tick();
            lat++;
        end
        ok = out_valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        res_0 = '0; res_1 = '0; res_2 = '0;
        tick(); tick();
        n_vec++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || digit_lo !== '0 ||
            digit_hi !== '0 || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b lo=%h hi=%h ovf=%b, want all 0",
                     in_ready, out_valid, digit_lo, digit_hi, ovf);
        end
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release_rdy: got %b want 0", in_ready);
        end
        tick();
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_first_edge_rdy: got %b want 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] va [5];
        logic [W-1:0] vb [5];
        logic [W-1:0] vc [5];
        logic [W+1:0] s;
        logic [W-1:0] one155;
        bit ok;
        int lat;
        one155 = '0; one155[W-1] = 1'b1;
        va[0] = W'(1);      vb[0] = W'(2); vc[0] = W'(3);
        va[1] = {W{1'b1}};  vb[1] = W'(1); vc[1] = '0;
        va[2] = {{RADIX{1'b0}}, {RADIX{1'b1}}}; vb[2] = W'(1); vc[2] = '0;
        va[3] = one155;     vb[3] = one155; vc[3] = one155;
        va[4] = {W{1'b1}};  vb[4] = {W{1'b1}}; vc[4] = {W{1'b1}};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s = ref_sum(va[i], vb[i], vc[i]);
            send(va[i], vb[i], vc[i], ok);
            wait_out(lat, ok);
            n_vec++;
            if (!ok || lat !== LAT) begin
                n_err++;
                $display("FAIL dir%0d_latency: got %0d (valid=%b) want %0d", i, lat, ok, LAT);
            end
            n_vec++;
            if ({digit_hi, digit_lo} !== s[W-1:0] || ovf !== (s[W+1:W] != 2'b00)) begin
                n_err++;
                $display("FAIL dir%0d_result: got hi=%h lo=%h ovf=%b want hi=%h lo=%h ovf=%b",
                         i, digit_hi, digit_lo, ovf, s[W-1:RADIX], s[RADIX-1:0],
                         s[W+1:W] != 2'b00);
            end
            tick();
            n_vec++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL dir%0d_handshake: got vld=%b rdy=%b want 0 1", i, out_valid, in_ready);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a, b, c;
        logic [W+1:0] s;
        bit ok;
        int lat;
        a = rnd156(); b = rnd156(); c = rnd156();
        s = ref_sum(a, b, c);
        out_ready = 1'b0;
        send(a, b, c, ok);
        wait_out(lat, ok);
        for (int i = 0; i < 10; i++) begin
            n_vec++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                {digit_hi, digit_lo} !== s[W-1:0] || ovf !== (s[W+1:W] != 2'b00)) begin
                n_err++;
                $display("FAIL bp_hold%0d: got vld=%b rdy=%b hi=%h lo=%h ovf=%b want 1 0 hi=%h lo=%h",
                         i, out_valid, in_ready, digit_hi, digit_lo, ovf,
                         s[W-1:RADIX], s[RADIX-1:0]);
            end
            res_0 = rnd156(); res_1 = rnd156(); res_2 = rnd156();
            in_valid = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || {digit_hi, digit_lo} !== s[W-1:0]) begin
            n_err++;
            $display("FAIL bp_release: got vld=%b rdy=%b hi=%h lo=%h want 0 1 hi=%h lo=%h",
                     out_valid, in_ready, digit_hi, digit_lo, s[W-1:RADIX], s[RADIX-1:0]);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int lat;
        logic [W+1:0] s;
        send({W{1'b1}}, W'(77), W'(5), ok);
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || digit_lo !== '0 ||
            digit_hi !== '0 || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_clear: got vld=%b rdy=%b lo=%h hi=%h ovf=%b want all 0",
                     out_valid, in_ready, digit_lo, digit_hi, ovf);
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_release: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
        end
        s = ref_sum(W'(5), W'(5), W'(5));
        out_ready = 1'b1;
        send(W'(5), W'(5), W'(5), ok);
        wait_out(lat, ok);
        n_vec++;
        if (!ok || {digit_hi, digit_lo} !== s[W-1:0] || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_fresh: got vld=%b lo=%h hi=%h ovf=%b want lo=%h hi=0 ovf=0",
                     ok, digit_lo, digit_hi, ovf, s[RADIX-1:0]);
        end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_soak(input int ntx);
        logic [W-1:0] a, b, c;
        logic [W+1:0] s;
        bit ok;
        int lat;
        int n;
        for (int t = 0; t < ntx; t++) begin
            a = rnd156(); b = rnd156(); c = rnd156();
            s = ref_sum(a, b, c);
            n = $urandom_range(0, 3);
            for (int g = 0; g < n; g++) tick();
            send(a, b, c, ok);
            lat = 0;
            while (!out_valid && lat < BOUND) begin
                res_0 = rnd156(); res_1 = rnd156(); res_2 = rnd156();
                in_valid = 1'($urandom_range(0, 1));
                out_ready = 1'($urandom_range(0, 1));
                tick();
                lat++;
            end
            in_valid = 1'b0;
            n = 0;
            out_ready = 1'($urandom_range(0, 1));
            while (out_valid && !out_ready && n < BOUND) begin
                tick();
                n++;
                out_ready = 1'($urandom_range(0, 1));
            end
            n_vec++;
            if (!out_valid || lat !== LAT || {digit_hi, digit_lo} !== s[W-1:0] ||
                ovf !== (s[W+1:W] != 2'b00)) begin
                n_err++;
                $display("FAIL soak%0d: got vld=%b lat=%0d hi=%h lo=%h ovf=%b want lat=%0d hi=%h lo=%h ovf=%b",
                         t, out_valid, lat, digit_hi, digit_lo, ovf, LAT,
                         s[W-1:RADIX], s[RADIX-1:0], s[W+1:W] != 2'b00);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_soak(1500);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
